// File: rtl/fetch_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : fetch_line_buffer
//  Description : Buffers fetched I-cache lines (pc, line, fault) in a small
//                circular store and hands them to decode one 32-bit
//                instruction per cycle over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_line_buffer #(
  parameter int LINE_WORDS = 4,
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_fault,
  input  logic [ADDR_WIDTH-1:0]    in_pc,
  input  logic [32*LINE_WORDS-1:0] in_line,
  output logic                     stall,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_pc,
  output logic [31:0]              out_insn,
  output logic                     out_fault
);

  localparam int c_woff_w = $clog2(LINE_WORDS);
  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_cnt_w  = $clog2(DEPTH + 1);
  localparam logic [c_cnt_w-1:0]  c_depth     = c_cnt_w'(DEPTH);
  localparam logic [c_woff_w-1:0] c_last_woff = c_woff_w'(LINE_WORDS - 1);

  // Entry storage; pc bits [1:0] are never used so they are not kept.
  logic [ADDR_WIDTH-1:2]    r_pc    [DEPTH];
  logic [32*LINE_WORDS-1:0] r_line  [DEPTH];
  logic [DEPTH-1:0]         r_fault;

  logic [c_ptr_w-1:0]  r_wptr;
  logic [c_ptr_w-1:0]  r_rptr;
  logic [c_cnt_w-1:0]  r_count;
  logic [c_woff_w-1:0] r_woff;

  logic                     w_push;
  logic                     w_pop;
  logic                     w_retire;
  logic [c_ptr_w-1:0]       w_next_rptr;
  logic [ADDR_WIDTH-1:2]    w_head_pc;
  logic [32*LINE_WORDS-1:0] w_head_line;
  logic                     w_head_fault;
  logic [31:0]              w_word;
  logic [c_woff_w-1:0]      w_in_woff;
  logic [1:0]               w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = in_pc[1:0];

  assign stall     = (r_count == c_depth);
  assign out_valid = (r_count != '0);

  // A flush swallows any push or pop presented in the same cycle.
  assign w_push   = in_valid && !stall && !flush;
  assign w_pop    = out_valid && out_ready && !flush;
  // Fault entries carry no usable data, so they retire after a single item.
  assign w_retire = w_pop && (w_head_fault || (r_woff == c_last_woff));

  assign w_next_rptr  = r_rptr + c_ptr_w'(1);
  assign w_head_pc    = r_pc[r_rptr];
  assign w_head_line  = r_line[r_rptr];
  assign w_head_fault = r_fault[r_rptr];
  assign w_word       = w_head_line[{r_woff, 5'b00000} +: 32];
  assign w_in_woff    = in_pc[c_woff_w+1:2];

  // Outputs are forced to zero while empty so stale storage never leaks out.
  assign out_fault = out_valid && w_head_fault;
  assign out_insn  = (out_valid && !w_head_fault) ? w_word : 32'h0;
  assign out_pc    = out_valid ? {w_head_pc[ADDR_WIDTH-1:c_woff_w+2], r_woff, 2'b00}
                               : '0;

  // Capture the presented line into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc[r_wptr]    <= in_pc[ADDR_WIDTH-1:2];
      r_line[r_wptr]  <= in_line;
      r_fault[r_wptr] <= in_fault;
    end
  end

  // Pointer, occupancy and word-offset bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_woff  <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_woff  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + c_ptr_w'(1);
      end
      if (w_retire) begin
        r_rptr <= w_next_rptr;
      end
      case ({w_push, w_retire})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      // The word offset reloads whenever a new line becomes the head.
      if (w_retire) begin
        if (r_count > c_cnt_w'(1)) begin
          r_woff <= r_pc[w_next_rptr][c_woff_w+1:2];
        end else if (w_push) begin
          r_woff <= w_in_woff;
        end else begin
          r_woff <= '0;
        end
      end else if (w_pop) begin
        r_woff <= r_woff + c_woff_w'(1);
      end else if (w_push && !out_valid) begin
        r_woff <= w_in_woff;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_buffer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_line_buffer
//  Description : Scoreboard bench for fetch_line_buffer. Stimulus expands
//                each accepted line into its expected instruction items; a
//                monitor compares the DUT output against the queue head.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_line_buffer;

  localparam int LW    = 4;
  localparam int DEPTH = 2;
  localparam int AW    = 32;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        fault;
    logic        last;
  } item_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_fault;
  logic [AW-1:0] in_pc;
  logic [32*LW-1:0] in_line;
  logic          stall;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [31:0]   out_insn;
  logic          out_fault;

  fetch_line_buffer #(.LINE_WORDS(LW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_fault(in_fault),
    .in_pc(in_pc), .in_line(in_line), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_insn(out_insn), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  item_t sb[$];      // expected items, oldest first
  item_t pq[$];      // items of a line accepted for the coming edge
  int    mlines   = 0;   // lines held by the model buffer
  bit    pend     = 0;
  bit    mon_en   = 0;
  int    nvec     = 0;
  int    nerr     = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected items of a line: from the requested word to the line end, or a
  // single zero-data item for a faulting fetch.
  function automatic void expand(input logic f, input logic [31:0] pc, input logic [32*LW-1:0] ln);
    item_t it;
    int w0 = int'((pc >> 2) % LW);
    logic [31:0] base = pc & ~32'(LW * 4 - 1);
    if (f) begin
      it.pc = pc & ~32'h3; it.insn = 32'h0; it.fault = 1'b1; it.last = 1'b1;
      pq.push_back(it);
    end else begin
      for (int w = w0; w < LW; w++) begin
        it.pc    = base + 32'(4 * w);
        it.insn  = ln[32*w +: 32];
        it.fault = 1'b0;
        it.last  = (w == LW - 1);
        pq.push_back(it);
      end
    end
  endfunction

  // One cycle of stimulus, driven 2 time units after the rising edge.
  task automatic drive(input logic v, input logic f, input logic [31:0] pc,
                       input logic [32*LW-1:0] ln, input logic rdy, input logic fl,
                       output bit acc);
    @(posedge clk); #2;
    in_valid = v; in_fault = f; in_pc = pc; in_line = ln;
    out_ready = rdy; flush = fl;
    acc = v && !fl && (mlines != DEPTH);
    if (acc) begin
      expand(f, pc, ln);
      pend = 1'b1;
    end
  endtask

  task automatic idle(input logic rdy);
    bit acc;
    drive(1'b0, 1'b0, 32'h0, '0, rdy, 1'b0, acc);
  endtask

  task automatic send_line(input logic f, input logic [31:0] pc,
                           input logic [32*LW-1:0] ln, input logic rdy);
    bit acc = 0;
    for (int i = 0; i < 40 && !acc; i++) drive(1'b1, f, pc, ln, rdy, 1'b0, acc);
    if (!acc) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (sb.size() != 0 || pend); i++) idle(1'b1);
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'h0);
    idle(1'b1);
  endtask

  function automatic logic [32*LW-1:0] rnd_line();
    logic [32*LW-1:0] l;
    for (int i = 0; i < LW; i++) l[32*i +: 32] = $urandom;
    return l;
  endfunction

  // Monitor: on each falling edge compare outputs to the scoreboard head,
  // then apply the handshake and any accepted push for the coming edge.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("stall", 32'(stall), 32'(mlines == DEPTH));
        if (sb.size() != 0 && out_valid) begin
          chk("out_pc", out_pc, sb[0].pc);
          chk("out_insn", out_insn, sb[0].insn);
          chk("out_fault", 32'(out_fault), 32'(sb[0].fault));
        end
        if (flush) begin
          sb.delete(); pq.delete(); mlines = 0; pend = 1'b0;
        end else begin
          if (sb.size() != 0 && out_ready) begin
            it = sb.pop_front();
            if (it.last) mlines--;
          end
          if (pend) begin
            while (pq.size() != 0) sb.push_back(pq.pop_front());
            mlines++;
            pend = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    bit acc;
    bit h_v;
    logic h_f, rdy, fl;
    logic [31:0] h_pc;
    logic [32*LW-1:0] h_ln;

    rst = 1'b1; in_valid = 0; in_fault = 0; in_pc = '0; in_line = '0;
    flush = 0; out_ready = 0;
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_insn", out_insn, 32'h0);
    chk("rst_out_fault", 32'(out_fault), 32'h0);
    #10 rst = 1'b0;
    mon_en = 1'b1;

    // Full line from word 0.
    send_line(1'b0, 32'h1000, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 1'b1);
    drain();
    // Line entered mid-way: two items only.
    send_line(1'b0, 32'h2008, rnd_line(), 1'b1);
    drain();
    // Fill to stall, refused third line, then release.
    send_line(1'b0, 32'h5000, rnd_line(), 1'b0);
    send_line(1'b0, 32'h5010, rnd_line(), 1'b0);
    h_ln = rnd_line();
    drive(1'b1, 1'b0, 32'h5020, h_ln, 1'b0, 1'b0, acc);
    drive(1'b1, 1'b0, 32'h5020, h_ln, 1'b0, 1'b0, acc);
    send_line(1'b0, 32'h5020, h_ln, 1'b1);
    drain();
    // Fault line then a normal line straight behind it.
    send_line(1'b1, 32'h3004, rnd_line(), 1'b1);
    send_line(1'b0, 32'h3100, rnd_line(), 1'b1);
    drain();
    // Flush mid-line together with a new line.
    send_line(1'b0, 32'h4000, rnd_line(), 1'b1);
    idle(1'b1);
    drive(1'b1, 1'b0, 32'h4100, rnd_line(), 1'b1, 1'b1, acc);
    idle(1'b1);
    drain();
    // Asynchronous reset while full and presenting an item.
    send_line(1'b0, 32'h6000, rnd_line(), 1'b0);
    send_line(1'b0, 32'h6010, rnd_line(), 1'b0);
    @(posedge clk); #1;
    chk("pre_rst_stall", 32'(stall), 32'h1);
    #2;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_stall", 32'(stall), 32'h0);
    chk("async_rst_out_pc", out_pc, 32'h0);
    sb.delete(); pq.delete(); mlines = 0; pend = 1'b0;
    in_valid = 0;
    #3 rst = 1'b0;
    mon_en = 1'b1;

    // Randomized traffic with held lines, random backpressure and flushes.
    h_v = 0; h_f = 0; h_pc = '0;
    for (int c = 0; c < 1500; c++) begin
      if (!h_v && $urandom_range(0, 2) != 0) begin
        h_v  = 1;
        h_f  = ($urandom_range(0, 7) == 0);
        h_pc = $urandom;
        h_ln = rnd_line();
      end
      rdy = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 40) == 0);
      drive(h_v, h_f, h_pc, h_ln, rdy, fl, acc);
      if (acc || fl) h_v = 0;
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
